// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: serial rx line to a held parallel byte with
// valid/read handshake, framing-error pulse and sticky overrun flag.
module uart_rx #(
    parameter int unsigned DBIT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rd,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            frame_err,
    output logic            overrun
);

    localparam int unsigned S_W = 4;
    localparam int unsigned N_W = 3;

    localparam logic [S_W-1:0] S_ZERO = S_W'(0);
    localparam logic [S_W-1:0] S_ONE  = S_W'(1);
    localparam logic [S_W-1:0] S_MID  = S_W'(7);
    localparam logic [S_W-1:0] S_END  = S_W'(15);
    localparam logic [N_W-1:0] N_ZERO = N_W'(0);
    localparam logic [N_W-1:0] N_ONE  = N_W'(1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } state_t;

    logic            rx_meta;
    logic            rx_s;

    state_t          state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;

    logic            done_ok_c;
    logic            frame_err_d;
    logic [DBIT-1:0] dout_d;
    logic            rx_valid_d;
    logic            overrun_d;

    // Two-flop synchronizer; idle-high reset so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            s_q     <= S_ZERO;
            n_q     <= N_ZERO;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    // Frame sequencing: start qualification at mid start bit, then one sample per 16 ticks.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        done_ok_c   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = S_ZERO;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = S_ZERO;
                            n_d     = N_ZERO;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_END) begin
                        s_d = S_ZERO;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_END) begin
                        if (rx_s) begin
                            done_ok_c = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BRK;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            ST_BRK: begin
                // A held-low line must go high before another start can be seen.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: a read in the completion cycle frees the slot for the new byte.
    always_comb begin
        dout_d     = dout;
        rx_valid_d = rx_valid;
        overrun_d  = overrun;

        if (done_ok_c) begin
            if (!rx_valid || rd) begin
                dout_d     = b_q;
                rx_valid_d = 1'b1;
                if (rx_valid) begin
                    overrun_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rd && rx_valid) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            dout      <= dout_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

endmodule
